uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive-side byte buffer between the UART receiver and the command interpreter.
- Absorbs bursts of received bytes while the interpreter is busy, and presents them one at a time as single-cycle valid pulses.
- Drives a hysteretic RTS flow-control output back to the host.
- Reports overflow with a sticky flag and exposes the fill level for debug.

Parameters:
- AW, 4, address width; FIFO depth DEPTH = 2**AW (16 entries).
- RTS_HIGH, 12, fill level at or above which rts_o deasserts; must satisfy RTS_LOW < RTS_HIGH <= DEPTH.
- RTS_LOW, 4, fill level at or below which rts_o reasserts.
- GAP, 2, minimum idle cycles after each rd_valid_o pulse before the next pulse may issue; range 1..7.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- wr_valid_i  in  1  single-cycle pulse from the UART receiver: byte received.
- wr_data_i  in  8  received byte; valid when wr_valid_i=1.
- rd_busy_i  in  1  command interpreter busy; 1 blocks pops.
- rd_valid_o  out  1  single-cycle pulse: rd_data_o holds a new byte.
- rd_data_o  out  8  byte popped from the FIFO; held until the next pop.
- rts_o  out  1  1 = host may send; 0 = host must stop.
- level_o  out  AW+1  current FIFO occupancy, range 0..DEPTH.
- overflow_o  out  1  sticky: a byte was dropped because the FIFO was full.
- clr_overflow_i  in  1  synchronous clear of overflow_o.

Behaviour:
- Reset values (async, rst_n_i=0):
  - rd_valid_o=0, rd_data_o=8'h00, rts_o=1, level_o=0, overflow_o=0.
  - Read and write pointers = 0; FSM in IDLE; gap counter = 0.
  - Memory contents are don't-care.
- Storage:
  - DEPTH x 8 register array.
  - wr_ptr and rd_ptr are AW bits and wrap modulo DEPTH.
  - A separate count register, AW+1 bits, drives level_o directly.
- Push:
  - wr_valid_i=1 and (count<DEPTH or pop in the same cycle): mem[wr_ptr]<=wr_data_i, wr_ptr increments.
  - wr_valid_i=1, count==DEPTH, no pop this cycle: byte dropped, overflow_o<=1, pointers and count unchanged.
- Pop: occurs in the cycle where the FSM is in IDLE, count>0 and rd_busy_i=0.
  - rd_data_o<=mem[rd_ptr], rd_ptr increments, rd_valid_o<=1 for exactly one cycle.
- Count update:
  - push only: +1; pop only: -1.
  - push and pop in the same cycle: unchanged; this is legal at full and at count==1.
  - Bypass from empty is not supported. A write to an empty FIFO pops no earlier than the next cycle.
- FSM:
  - IDLE: pop when the condition holds, then go to HOLD with gap counter = GAP.
  - HOLD: decrement the gap counter each cycle; return to IDLE when it reaches 0. No pops occur in HOLD.
  - rd_busy_i is sampled only in IDLE.
  - Purpose of HOLD: gives the interpreter time to raise rd_busy_i.
- Latency:
  - wr_valid_i in cycle N with FIFO empty, rd_busy_i=0 and FSM in IDLE gives rd_valid_o=1 in cycle N+2.
  - Pulse spacing under continuous availability: one pulse every GAP+1 cycles.
- RTS (registered, computed from the next-state count):
  - next_count >= RTS_HIGH: rts_o<=0.
  - next_count <= RTS_LOW: rts_o<=1.
  - Otherwise rts_o holds its value.
- Overflow:
  - clr_overflow_i=1 clears overflow_o.
  - If clr_overflow_i and a new drop coincide in the same cycle, the set wins and overflow_o=1.
- rd_busy_i held high indefinitely: the FIFO fills, rts_o falls at RTS_HIGH, and further bytes are dropped with overflow flagged.
- Reset asserted mid-operation: all contents are discarded immediately and any in-flight pulse is cut.
- The first pop after reset reads the byte written first, in order.

Test Plan:
- Reset -> rts_o=1, level_o=0, rd_valid_o=0, overflow_o=0.
- Single write 8'hA5 at cycle N, rd_busy_i=0 -> rd_valid_o pulse at N+2 with rd_data_o=8'hA5; level_o returns to 0.
- rd_busy_i=1; write bytes 8'h00..8'h0B (12 bytes) -> rts_o=0 the cycle after the 12th write. Drop rd_busy_i -> bytes pop in order, spaced 3 cycles apart (GAP=2); rts_o=1 once level_o reaches 4.
- rd_busy_i=1; write 17 bytes -> level_o=16; overflow_o=1 after the 17th write; the 17th byte is never output. clr_overflow_i pulse -> overflow_o=0.
- FIFO full; wr_valid_i coincides with a pop -> byte accepted, level_o stays 16, overflow_o stays 0; final output order is preserved across the pointer wrap.
- 5 bytes queued; assert rst_n_i=0 between pops -> outputs return to reset values immediately; no further rd_valid_o after release.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART receiver and the command interpreter.
// Pops are rate-limited by a post-pulse hold window; RTS has hysteresis on the fill level.
module uart_rx_fifo #(
    parameter int AW       = 4,
    parameter int RTS_HIGH = 12,
    parameter int RTS_LOW  = 4,
    parameter int GAP      = 2
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          wr_valid_i,
    input  logic [7:0]    wr_data_i,
    input  logic          rd_busy_i,
    output logic          rd_valid_o,
    output logic [7:0]    rd_data_o,
    output logic          rts_o,
    output logic [AW:0]   level_o,
    output logic          overflow_o,
    input  logic          clr_overflow_i
);

    localparam int DEPTH = 2**AW;
    localparam logic [AW:0] FULL      = (AW+1)'(DEPTH);
    localparam logic [AW:0] HIGH_MARK = (AW+1)'(RTS_HIGH);
    localparam logic [AW:0] LOW_MARK  = (AW+1)'(RTS_LOW);
    localparam logic [2:0]  GAP_INIT  = 3'(GAP);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   next_count;
    logic [2:0]    gap_cnt;
    logic          pop;
    logic          push;
    logic          drop;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a byte then.
    assign pop  = (state == IDLE) && (count != '0) && !rd_busy_i;
    assign push = wr_valid_i && ((count != FULL) || pop);
    assign drop = wr_valid_i && (count == FULL) && !pop;

    assign level_o = count;

    always_comb begin
        next_count = count;
        if (push && !pop) begin
            next_count = count + 1'b1;
        end else if (pop && !push) begin
            next_count = count - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rd_valid_o <= 1'b0;
            rd_data_o  <= 8'h00;
            rts_o      <= 1'b1;
            overflow_o <= 1'b0;
        end else begin
            rd_valid_o <= 1'b0;
            count      <= next_count;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        rd_data_o  <= mem[rd_ptr];
                        rd_ptr     <= rd_ptr + 1'b1;
                        rd_valid_o <= 1'b1;
                        gap_cnt    <= GAP_INIT;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    gap_cnt <= gap_cnt - 3'd1;
                    if (gap_cnt == 3'd1) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Between the two marks RTS keeps its previous value.
            if (next_count >= HIGH_MARK) begin
                rts_o <= 1'b0;
            end else if (next_count <= LOW_MARK) begin
                rts_o <= 1'b1;
            end

            if (drop) begin
                overflow_o <= 1'b1;
            end else if (clr_overflow_i) begin
                overflow_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_uart_rx_fifo;

    localparam int AW       = 4;
    localparam int DEPTH    = 16;
    localparam int RTS_HIGH = 12;
    localparam int RTS_LOW  = 4;
    localparam int GAP      = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_busy = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rts;
    logic [AW:0] level;
    logic       overflow;

    int n_cmp = 0;
    int n_fail = 0;
    int cycle = 0;

    uart_rx_fifo #(
        .AW(AW), .RTS_HIGH(RTS_HIGH), .RTS_LOW(RTS_LOW), .GAP(GAP)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .wr_valid_i(wr_valid),
        .wr_data_i(wr_data),
        .rd_busy_i(rd_busy),
        .rd_valid_o(rd_valid),
        .rd_data_o(rd_data),
        .rts_o(rts),
        .level_o(level),
        .overflow_o(overflow),
        .clr_overflow_i(clr_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Reference model: a byte queue, a count of edges since the last pop, and sticky flags.
    logic [7:0] mq[$];
    int         since_pop = GAP;
    logic       exp_valid = 1'b0;
    logic [7:0] exp_data = 8'h00;
    logic       exp_rts = 1'b1;
    logic       exp_ovf = 1'b0;
    logic       m_pop;
    logic       m_drop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            since_pop = GAP;
            exp_valid = 1'b0;
            exp_data  = 8'h00;
            exp_rts   = 1'b1;
            exp_ovf   = 1'b0;
        end else begin
            m_pop  = (mq.size() > 0) && !rd_busy && (since_pop >= GAP);
            m_drop = 1'b0;
            exp_valid = m_pop;
            if (m_pop) exp_data = mq.pop_front();
            if (wr_valid) begin
                if (mq.size() < DEPTH) mq.push_back(wr_data);
                else m_drop = 1'b1;
            end
            if (m_drop) exp_ovf = 1'b1;
            else if (clr_ovf) exp_ovf = 1'b0;
            if (m_pop) since_pop = 0;
            else if (since_pop < GAP) since_pop++;
            if (mq.size() >= RTS_HIGH) exp_rts = 1'b0;
            else if (mq.size() <= RTS_LOW) exp_rts = 1'b1;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL %s: timed out, got no completion, expected completion", name);
    endtask

    // Every cycle: compare against the model and log output pulses for ordering checks.
    logic [7:0] got_q[$];
    int         pulse_cyc[$];

    always @(negedge clk) begin
        check_output("rd_valid", 32'(rd_valid), 32'(exp_valid));
        check_output("rd_data", 32'(rd_data), 32'(exp_data));
        check_output("rts", 32'(rts), 32'(exp_rts));
        check_output("level", 32'(level), 32'(mq.size()));
        check_output("overflow", 32'(overflow), 32'(exp_ovf));
        if (rd_valid === 1'b1) begin
            got_q.push_back(rd_data);
            pulse_cyc.push_back(cycle);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [7:0] b);
        wr_valid = 1'b1;
        wr_data  = b;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k;
        for (k = 0; k < 300; k++) begin
            if (level == '0) break;
            tick();
        end
        if (k == 300) timeout_fail(name);
        repeat (4) tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n_before;
        int k;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_rts", 32'(rts), 32'd1);
        check_output("reset_level", 32'(level), 32'd0);
        check_output("reset_valid", 32'(rd_valid), 32'd0);
        check_output("reset_ovf", 32'(overflow), 32'd0);
        check_output("reset_data", 32'(rd_data), 32'h00);
        rst_n = 1'b1;
        tick();

        $display("[TB] single byte latency");
        apply_stimulus(8'hA5);
        check_output("lat_n1_valid", 32'(rd_valid), 32'd0);
        tick();
        check_output("lat_n2_valid", 32'(rd_valid), 32'd1);
        check_output("lat_n2_data", 32'(rd_data), 32'hA5);
        tick();
        check_output("lat_after_valid", 32'(rd_valid), 32'd0);
        check_output("lat_after_level", 32'(level), 32'd0);
        repeat (3) tick();

        $display("[TB] rts hysteresis and pulse spacing");
        rd_busy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(8'(i));
            if (i == 10) check_output("rts_at_11", 32'(rts), 32'd1);
        end
        check_output("rts_at_12", 32'(rts), 32'd0);
        check_output("level_12", 32'(level), 32'd12);
        got_q.delete();
        pulse_cyc.delete();
        rd_busy = 1'b0;
        wait_drain("drain_12");
        check_output("drain12_count", 32'(got_q.size()), 32'd12);
        for (int i = 0; i < 12 && i < got_q.size(); i++)
            check_output("drain12_order", 32'(got_q[i]), 32'(i));
        for (int i = 1; i < 12 && i < pulse_cyc.size(); i++)
            check_output("pulse_spacing", 32'(pulse_cyc[i] - pulse_cyc[i-1]), 32'd3);
        check_output("rts_after_drain", 32'(rts), 32'd1);

        $display("[TB] overflow");
        rd_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(8'(8'h20 + i));
            if (i == 15) begin
                check_output("level_full", 32'(level), 32'd16);
                check_output("ovf_at_16", 32'(overflow), 32'd0);
            end
        end
        check_output("level_after_17", 32'(level), 32'd16);
        check_output("ovf_after_17", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_output("ovf_cleared", 32'(overflow), 32'd0);

        $display("[TB] push and pop at full");
        got_q.delete();
        rd_busy  = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 8'h31;
        tick();
        wr_valid = 1'b0;
        check_output("full_pp_level", 32'(level), 32'd16);
        check_output("full_pp_ovf", 32'(overflow), 32'd0);
        check_output("full_pp_valid", 32'(rd_valid), 32'd1);
        check_output("full_pp_data", 32'(rd_data), 32'h20);
        wait_drain("drain_full");
        check_output("wrap_count", 32'(got_q.size()), 32'd17);
        for (int i = 0; i < 16 && i < got_q.size(); i++)
            check_output("wrap_order", 32'(got_q[i]), 32'(8'h20 + i));
        if (got_q.size() == 17) check_output("wrap_last", 32'(got_q[16]), 32'h31);

        $display("[TB] reset mid-operation");
        rd_busy = 1'b1;
        for (int i = 0; i < 5; i++) apply_stimulus(8'(8'h40 + i));
        rd_busy = 1'b0;
        for (k = 0; k < 10; k++) begin
            tick();
            if (rd_valid === 1'b1) break;
        end
        if (k == 10) timeout_fail("first_pulse");
        #1;
        rst_n = 1'b0;
        #1;
        check_output("midrst_valid", 32'(rd_valid), 32'd0);
        check_output("midrst_level", 32'(level), 32'd0);
        check_output("midrst_rts", 32'(rts), 32'd1);
        check_output("midrst_ovf", 32'(overflow), 32'd0);
        check_output("midrst_data", 32'(rd_data), 32'h00);
        repeat (2) tick();
        rst_n = 1'b1;
        n_before = got_q.size();
        repeat (10) tick();
        check_output("postrst_pulses", 32'(got_q.size()), 32'(n_before));
        check_output("postrst_level", 32'(level), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
